// File: rtl/sdram_arbiter.sv
// Registered one-grant-at-a-time SDRAM arbiter: real-time requesters beat batch
// requesters, with round-robin inside each class and sticky protocol/timeout flags.
module sdram_arbiter #(
    parameter int             N       = 5,
    parameter logic [N-1:0]   RT_MASK = 5'b11000,
    parameter int             AW      = 23,
    parameter int             DW      = 32,
    parameter int             TIMEOUT = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      req_read,
    input  logic [N-1:0]      req_write,
    input  logic [N*AW-1:0]   req_addr,
    input  logic [N*DW-1:0]   req_writedata,
    output logic [DW-1:0]     req_readdata,
    output logic [N-1:0]      req_finished,
    output logic [AW-1:0]     sdram_addr,
    output logic              sdram_read,
    output logic              sdram_write,
    output logic [DW-1:0]     sdram_writedata,
    input  logic [DW-1:0]     sdram_readdata,
    input  logic              sdram_finished,
    output logic [N-1:0]      o_grant,
    output logic              o_busy,
    output logic              o_proto_err,
    output logic              o_timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr_rt;
    logic [PW-1:0]   r_ptr_batch;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_grant;
    logic            r_busy;
    logic            r_read;
    logic            r_write;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_proto_err;
    logic            r_timeout;

    logic [N-1:0]    w_act;
    logic [N-1:0]    w_rt_req;
    logic [N-1:0]    w_batch_req;
    logic            w_use_rt;
    logic            w_valid;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_next_ptr;
    logic            w_done;

    // First set bit of cand scanning upward from ptr with wrap; the reverse loop
    // lets the lowest offset overwrite any later candidate.
    function automatic logic [PW-1:0] pick(input logic [N-1:0] cand, input logic [PW-1:0] ptr);
        int j;
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (cand[j]) pick = PW'(j);
        end
    endfunction

    assign w_act       = req_read | req_write;
    assign w_rt_req    = w_act & RT_MASK;
    assign w_batch_req = w_act & ~RT_MASK;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_use_rt   = |w_rt_req;
        w_valid    = |w_act;
        w_win      = w_use_rt ? pick(w_rt_req, r_ptr_rt) : pick(w_batch_req, r_ptr_batch);
        w_next_ptr = (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
    end

    assign w_done       = (r_state == ST_BUSY) && sdram_finished;
    assign req_finished = w_done ? r_grant : '0;
    assign req_readdata = w_done ? sdram_readdata : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr_rt    <= '0;
            r_ptr_batch <= '0;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_proto_err <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant        <= '0;
                        r_grant[w_win] <= 1'b1;
                        r_busy         <= 1'b1;
                        r_addr         <= req_addr[w_win*AW +: AW];
                        r_wdata        <= req_writedata[w_win*DW +: DW];
                        r_write        <= req_write[w_win];
                        r_read         <= ~req_write[w_win];
                        if (req_read[w_win] && req_write[w_win]) r_proto_err <= 1'b1;
                        if (w_use_rt) r_ptr_rt    <= w_next_ptr;
                        else          r_ptr_batch <= w_next_ptr;
                        r_cnt          <= '0;
                        r_state        <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (sdram_finished) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        // Saturate so a stuck transaction cannot wrap the counter.
                        if (r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(TIMEOUT - 1)) r_timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_grant         = r_grant;
    assign o_busy          = r_busy;
    assign sdram_read      = r_read;
    assign sdram_write     = r_write;
    assign sdram_addr      = r_addr;
    assign sdram_writedata = r_wdata;
    assign o_proto_err     = r_proto_err;
    assign o_timeout       = r_timeout;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: single read, RT priority, round-robin,
// protocol error, timeout and asynchronous reset during a transaction.
module tb_sdram_arbiter;

    localparam int N       = 5;
    localparam int AW      = 23;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4096;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_writedata;
    logic [DW-1:0]     req_readdata;
    logic [N-1:0]      req_finished;
    logic [AW-1:0]     sdram_addr;
    logic              sdram_read;
    logic              sdram_write;
    logic [DW-1:0]     sdram_writedata;
    logic [DW-1:0]     sdram_readdata;
    logic              sdram_finished;
    logic [N-1:0]      o_grant;
    logic              o_busy;
    logic              o_proto_err;
    logic              o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    sdram_arbiter #(.N(N), .RT_MASK(5'b11000), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_writedata   (req_writedata),
        .req_readdata    (req_readdata),
        .req_finished    (req_finished),
        .sdram_addr      (sdram_addr),
        .sdram_read      (sdram_read),
        .sdram_write     (sdram_write),
        .sdram_writedata (sdram_writedata),
        .sdram_readdata  (sdram_readdata),
        .sdram_finished  (sdram_finished),
        .o_grant         (o_grant),
        .o_busy          (o_busy),
        .o_proto_err     (o_proto_err),
        .o_timeout       (o_timeout)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic set_req(input int g, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_read[g]             = rd;
        req_write[g]            = wr;
        req_addr[g*AW +: AW]    = a;
        req_writedata[g*DW +: DW] = d;
    endtask

    task automatic do_reset();
        i_rst          = 1'b0;
        req_read       = '0;
        req_write      = '0;
        req_addr       = '0;
        req_writedata  = '0;
        sdram_readdata = '0;
        sdram_finished = 1'b0;
        #1;
        check("rst_grant", 64'(o_grant), 64'h0);
        check("rst_busy",  64'(o_busy), 64'h0);
        check("rst_cmd",   64'({sdram_read, sdram_write}), 64'h0);
        check("rst_addr",  64'(sdram_addr), 64'h0);
        check("rst_flags", 64'({o_proto_err, o_timeout}), 64'h0);
        tick();
        i_rst = 1'b1;
    endtask

    // Entry: at a negedge where the command for requester g must already be on the bus.
    // Exit: at the negedge one IDLE cycle after completion (next command visible, if any).
    task automatic run_txn(input string tag, input int g, input bit is_wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] rdata, input int lat, input bit drop);
        check({tag, "_grant"}, 64'(o_grant), 64'(1) << g);
        check({tag, "_busy"},  64'(o_busy), 64'h1);
        check({tag, "_cmd"},   64'({sdram_read, sdram_write}), is_wr ? 64'h1 : 64'h2);
        check({tag, "_addr"},  64'(sdram_addr), 64'(a));
        if (is_wr) check({tag, "_wdata"}, 64'(sdram_writedata), 64'(d));
        repeat (lat) tick();
        check({tag, "_held"}, 64'({sdram_read, sdram_write, sdram_addr}),
              64'({~is_wr, is_wr, a}));
        sdram_readdata = rdata;
        sdram_finished = 1'b1;
        #1;
        check({tag, "_fin"},   64'(req_finished), 64'(1) << g);
        check({tag, "_rdata"}, 64'(req_readdata), 64'(rdata));
        tick();
        sdram_finished = 1'b0;
        if (drop) begin
            req_read[g]  = 1'b0;
            req_write[g] = 1'b0;
        end
        #1;
        check({tag, "_idle"}, 64'({o_grant, o_busy, sdram_read, sdram_write, req_finished}), 64'h0);
        tick();
    endtask

    initial begin
        // Single read on requester 1
        do_reset();
        set_req(1, 1'b1, 1'b0, 23'h00_1234, 32'h0);
        #1;
        check("rd1_pre_busy", 64'(o_busy), 64'h0);
        tick();
        run_txn("rd1", 1, 1'b0, 23'h00_1234, 32'h0, 32'hCAFE_BEEF, 3, 1'b1);
        check("rd1_stay_idle", 64'(o_busy), 64'h0);
        sdram_finished = 1'b1;
        #1;
        check("idle_fin_ignored", 64'(req_finished), 64'h0);
        tick();
        sdram_finished = 1'b0;
        check("idle_fin_no_grant", 64'(o_grant), 64'h0);

        // RT priority: 4 first, then batch 0, then batch 2
        do_reset();
        set_req(0, 1'b0, 1'b1, 23'h00_0100, 32'h0000_00A0);
        set_req(2, 1'b1, 1'b0, 23'h00_0200, 32'h0);
        set_req(4, 1'b1, 1'b0, 23'h00_0400, 32'h0);
        tick();
        run_txn("rt4", 4, 1'b0, 23'h00_0400, 32'h0, 32'h4444_0004, 2, 1'b1);
        run_txn("rt0", 0, 1'b1, 23'h00_0100, 32'h0000_00A0, 32'h0, 2, 1'b1);
        run_txn("rt2", 2, 1'b0, 23'h00_0200, 32'h0, 32'h2222_0002, 2, 1'b1);
        check("rt_done_idle", 64'(o_busy), 64'h0);

        // Round-robin among held batch requesters 0,1,2
        do_reset();
        set_req(0, 1'b1, 1'b0, 23'h00_0010, 32'h0);
        set_req(1, 1'b1, 1'b0, 23'h00_0011, 32'h0);
        set_req(2, 1'b1, 1'b0, 23'h00_0012, 32'h0);
        tick();
        for (int k = 0; k < 6; k++) begin
            run_txn($sformatf("rr%0d", k), k % 3, 1'b0, 23'(32'h10 + 32'(k % 3)),
                    32'h0, 32'h5000_0000 + 32'(k), 1, 1'b0);
        end

        // Protocol error: read and write together on requester 3
        do_reset();
        set_req(3, 1'b1, 1'b1, 23'h00_0333, 32'hDEAD_BEEF);
        #1;
        check("perr_pre", 64'(o_proto_err), 64'h0);
        tick();
        check("perr_set", 64'(o_proto_err), 64'h1);
        run_txn("perr", 3, 1'b1, 23'h00_0333, 32'hDEAD_BEEF, 32'h0, 2, 1'b1);
        check("perr_sticky", 64'(o_proto_err), 64'h1);

        // Timeout: finished withheld past TIMEOUT
        do_reset();
        set_req(0, 1'b1, 1'b0, 23'h00_0042, 32'h0);
        tick();
        check("to_cmd", 64'({o_grant, sdram_read}), 64'({5'b00001, 1'b1}));
        repeat (TIMEOUT - 10) tick();
        check("to_not_yet", 64'(o_timeout), 64'h0);
        repeat (12) tick();
        check("to_set", 64'(o_timeout), 64'h1);
        check("to_held", 64'({o_busy, o_grant, sdram_read, sdram_addr}),
              64'({1'b1, 5'b00001, 1'b1, 23'h00_0042}));
        sdram_readdata = 32'h7777_0042;
        sdram_finished = 1'b1;
        #1;
        check("to_late_fin", 64'({req_finished, req_readdata}), 64'({5'b00001, 32'h7777_0042}));
        tick();
        sdram_finished = 1'b0;
        req_read[0]    = 1'b0;
        #1;
        check("to_done", 64'({o_busy, o_timeout}), 64'h1);

        // Asynchronous reset mid-BUSY
        do_reset();
        set_req(1, 1'b1, 1'b0, 23'h00_0011, 32'h0);
        tick();
        check("arst_cmd", 64'({o_grant, sdram_read}), 64'({5'b00010, 1'b1}));
        #2;
        i_rst          = 1'b0;
        sdram_finished = 1'b1;
        #1;
        check("arst_drop", 64'({o_grant, o_busy, sdram_read, sdram_write}), 64'h0);
        check("arst_no_fin", 64'(req_finished), 64'h0);
        tick();
        i_rst          = 1'b1;
        sdram_finished = 1'b0;
        req_read       = 5'b00101;
        tick();
        check("arst_ptr0", 64'(o_grant), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
